// File: rtl/mixer_scheduler.sv
// Four-channel real-by-complex mixer sharing one signed 16x18 multiplier.
// Ports: ipClk, ipReset (async low), ipInput/ipNCO[N] in, ipClearOverflow,
//   opOutput[N] (I,Q,Valid), opOverflow (sticky drop flags), opBusy.
package mixer_pkg;
  localparam int N = 4;

  typedef struct packed {
    logic               Valid;
    logic signed [15:0] Data;
  } data_stream_t;

  typedef struct packed {
    logic               Valid;
    logic signed [17:0] I;
    logic signed [17:0] Q;
  } complex_stream_t;
endpackage

module mixer_scheduler
  import mixer_pkg::*;
(
  input  logic                    ipClk,
  input  logic                    ipReset,
  input  data_stream_t    [N-1:0] ipInput,
  input  complex_stream_t [N-1:0] ipNCO,
  input  logic            [N-1:0] ipClearOverflow,
  output complex_stream_t [N-1:0] opOutput,
  output logic            [N-1:0] opOverflow,
  output logic                    opBusy
);

  typedef enum logic [1:0] {
    IDLE,
    MUL_I,
    MUL_Q
  } state_t;

  state_t             state;
  logic [N-1:0]       pend;
  logic signed [15:0] slot_d [N];
  logic signed [17:0] slot_i [N];
  logic signed [17:0] slot_q [N];
  logic [1:0]         ptr;
  logic [1:0]         iss_ch;
  logic signed [15:0] iss_d;
  logic signed [17:0] iss_q;
  logic signed [17:0] hold_i;
  logic signed [33:0] prod;

  logic [1:0]         gnt;
  logic               found;
  logic               take;
  logic [N-1:0]       gnt_oh;
  logic [N-1:0]       acc;
  logic [N-1:0]       drop;
  logic signed [15:0] mul_a;
  logic signed [17:0] mul_b;
  logic signed [33:0] mul_p;
  logic               unused_nco_valid;

  // Round-robin search starting at ptr.
  always_comb begin
    gnt   = ptr;
    found = 1'b0;
    for (int o = 0; o < N; o++) begin
      if (!found && pend[ptr + 2'(o)]) begin
        gnt   = ptr + 2'(o);
        found = 1'b1;
      end
    end
  end

  assign take = found && (state == IDLE || state == MUL_Q);

  // A slot being granted this cycle may be refilled without a drop.
  always_comb begin
    gnt_oh           = '0;
    acc              = '0;
    drop             = '0;
    unused_nco_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      gnt_oh[k] = take && (gnt == 2'(k));
      acc[k]    = ipInput[k].Valid && (!pend[k] || gnt_oh[k]);
      drop[k]   = ipInput[k].Valid && pend[k] && !gnt_oh[k];
      unused_nco_valid = unused_nco_valid ^ ipNCO[k].Valid;
    end
  end

  // Grant cycle feeds Data*I straight from the slot; MulI uses Data*Q.
  always_comb begin
    mul_a = (state == MUL_I) ? iss_d : slot_d[gnt];
    mul_b = (state == MUL_I) ? iss_q : slot_i[gnt];
    mul_p = 34'(mul_a) * 34'(mul_b);
  end

  assign opBusy = (state != IDLE) || (|pend);

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state      <= IDLE;
      pend       <= '0;
      ptr        <= '0;
      iss_ch     <= '0;
      iss_d      <= '0;
      iss_q      <= '0;
      hold_i     <= '0;
      prod       <= '0;
      opOutput   <= '0;
      opOverflow <= '0;
      for (int k = 0; k < N; k++) begin
        slot_d[k] <= '0;
        slot_i[k] <= '0;
        slot_q[k] <= '0;
      end
    end else begin
      case (state)
        IDLE:    if (found) state <= MUL_I;
        MUL_I:   state <= MUL_Q;
        MUL_Q:   state <= found ? MUL_I : IDLE;
        default: state <= IDLE;
      endcase

      pend       <= (pend & ~gnt_oh) | acc;
      opOverflow <= (opOverflow & ~ipClearOverflow) | drop;

      for (int k = 0; k < N; k++) begin
        opOutput[k].Valid <= 1'b0;
        if (acc[k]) begin
          slot_d[k] <= ipInput[k].Data;
          slot_i[k] <= ipNCO[k].I;
          slot_q[k] <= ipNCO[k].Q;
        end
      end

      if (take) begin
        ptr    <= gnt + 2'd1;
        iss_ch <= gnt;
        iss_d  <= slot_d[gnt];
        iss_q  <= slot_q[gnt];
      end

      if (take || state == MUL_I) prod <= mul_p;
      if (state == MUL_I) hold_i <= prod[32:15];

      if (state == MUL_Q) begin
        opOutput[iss_ch].Valid <= 1'b1;
        opOutput[iss_ch].I     <= hold_i;
        opOutput[iss_ch].Q     <= prod[32:15];
      end
    end
  end

endmodule

// File: doc/mixer_scheduler.md
# mixer_scheduler

Four-channel real-by-complex mixer built around one shared signed 16x18 multiplier, time-multiplexed between channels by a round-robin scheduler. Each channel presents a DATA_STREAM sample and a COMPLEX_STREAM NCO value. The block buffers one pending job per channel, issues I and Q products back-to-back on the shared multiplier, and returns a COMPLEX_STREAM result on that channel's output. It sits between the per-channel NCOs/ADC streams and the downstream per-channel filters. It replaces four separate mixers where multiplier count matters.

## Interface
- N, 4: channel count; fixed at 4 for this release. Pointer and grant are 2-bit.
- ipClk  in  1  clock; all logic on the rising edge.
- ipReset  in  1  reset; asynchronous, active-low.
- ipInput[N]  in  DATA_STREAM  per channel: Data is signed 16-bit Q15; Valid is a single-cycle strobe.
- ipNCO[N]  in  COMPLEX_STREAM  per channel: I and Q are signed 18-bit Q17. Sampled only on the Valid cycle of the matching ipInput.
- ipClearOverflow  in  N  per-channel pulse; clears opOverflow[k].
- opOutput[N]  out  COMPLEX_STREAM  per channel: I and Q are signed 18-bit; Valid is a one-cycle pulse.
- opOverflow  out  N  sticky per-channel flag: a job was dropped.
- opBusy  out  1  high while the scheduler state is not Idle or any job is pending.

## Operation
- Per-channel pending slot. On ipInput[k].Valid, latch Data, NCO.I and NCO.Q, and set Pend[k].
- If Pend[k] is already set and not being granted in the same cycle:
  - drop the new sample;
  - keep the old job;
  - set opOverflow[k].
- Grant in the same cycle as a new Valid on that channel: the slot is refilled with the new sample. No overflow.
- Overflow set and ipClearOverflow[k] in the same cycle: set wins.
- Scheduler FSM states:
  - Idle → MulI when any Pend bit is set.
  - MulI → MulQ, always.
  - MulQ → MulI if any Pend bit is set, otherwise Idle.
- Grant is taken on entry to MulI, from Idle or MulQ.
  - Search order: Ptr, Ptr+1, … mod 4. Grant the first pending channel g.
  - Clear Pend[g]. Set Ptr to g+1 mod 4. Copy the slot's operands into the issue registers.
- Multiplier: one registered signed 16x18 product, Prod[33:0].
  - MulI: Prod <= Data*I.
  - MulQ: Prod <= Data*Q, and the I result holding register <= Prod[32:15].
  - Cycle after MulQ: opOutput[g].I <= held I result, opOutput[g].Q <= Prod[32:15], opOutput[g].Valid <= 1.
- Arithmetic: truncate to bits [32:15] with no rounding and no saturation. The only overflow case, (−32768)*(−131072), wraps to −131072.
- Output I/Q hold their last value until the same channel is written again. Valid is high for exactly one cycle per completed job.

## Timing
- Reset values: all Valid 0, all I/Q 0, opOverflow 0, opBusy 0, Pend 0, Ptr 0, state Idle.
- Reset assertion takes effect immediately, including mid-job. In-flight and pending jobs are discarded and no Valid is produced.
- Latency when the scheduler is Idle. With Valid sampled at edge E0:
  - Pend is set at E0.
  - MulI product is registered at E1.
  - MulQ product is registered at E2.
  - opOutput.Valid is high from E3 to E4.
- Total latency: 3 cycles.
- Throughput: the multiplier is busy every cycle while jobs are pending. One job completes per 2 cycles in aggregate.
- Each channel can sustain 1 sample per 8 cycles under full load with no overflow.
- Worst-case wait for a granted job: 6 cycles, behind three other channels.
- Output Valid pulses on different channels are never in the same cycle. They are at least 2 cycles apart.

## Test plan
- Single job on ch0: Data=16384, I=65536, Q=−65536 → ch0 Valid 3 cycles later with I=32768, Q=−32768. No other channel Valid. opOverflow=0.
- Wrap corner on ch2: Data=−32768, I=−131072, Q=131071 → I=−131072 (wrap), Q=−131071.
- All four channels Valid in the same cycle, Ptr=0, distinct data → outputs in order ch0, ch1, ch2, ch3 at cycles 3, 5, 7, 9, each with correct products. opBusy falls after the ch3 output.
- Ch1 strobed on two consecutive cycles while the scheduler is busy on ch0 → second sample dropped and opOverflow[1]=1. Result is from the first sample. ipClearOverflow[1] pulse → 0. Clear and a new overflow in the same cycle → stays 1.
- Fairness: ch0 and ch3 strobed every 8 cycles for 100 jobs → grants alternate between them. No overflow. Every sample produces exactly one correct result.
- Reset asserted in the MulQ cycle of a ch0 job with ch1 pending → outputs, Pend and flags are 0 immediately. No Valid appears after release. A new ch1 job after release completes with the 3-cycle latency.
